bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential converter from four packed BCD digits (thousands, hundreds, tens, ones) back to a 14-bit binary frequency value. It is the inverse of the BCD block that drives the frequency counter's display. It sits on the entry path, so a frequency set from the display/keypad side can be used by the binary counter logic. It uses iterative reverse double-dabble: one shift-and-correct step per clock, with a start/done handshake.

Parameters:
BIN_W, 14, width of binary result; must be >= 14 (9999 < 2^14); iteration count equals BIN_W

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
thous  input  4  thousands BCD digit
hunds  input  4  hundreds BCD digit
tens  input  4  tens BCD digit
ones  input  4  ones BCD digit
freq  output  BIN_W  binary result; registered, held until the next successful conversion
busy  output  1  high while converting
done  output  1  single-cycle pulse when a request finishes (good or bad)
err  output  1  request rejected: invalid digit; held until the next accepted start

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (async assert, any state): state=IDLE; freq=0, busy=0, done=0, err=0; internal shift register and counter cleared. A conversion in flight is aborted with no done pulse.
- Internal: 16-bit BCD shift register sr_bcd = {thous,hunds,tens,ones}; BIN_W-bit sr_bin; iteration counter cnt of width ceil(log2(BIN_W+1)).
- States:
  - IDLE: busy=0. On an edge with start=1:
    - If all digits <= 9: load sr_bcd, clear sr_bin and cnt, clear err, go to SHIFT, busy=1 from the next cycle.
    - If any digit > 9: go to REJECT; nothing is loaded.
  - SHIFT, one step per edge:
    - {sr_bcd,sr_bin} shifted right by 1 (sr_bcd[0] enters sr_bin MSB).
    - Each post-shift BCD nibble >= 8 has 3 subtracted (4-bit, no borrow across nibbles).
    - cnt increments.
    - On the edge where cnt reaches BIN_W-1 (the BIN_W-th step): freq <= post-shift sr_bin, done <= 1, busy <= 0, go to IDLE.
  - REJECT (one cycle): done=1, err=1, freq unchanged, busy=0; return to IDLE.
- Latency: done is high in the cycle starting BIN_W edges after the start-sampling edge (14 for default). Rejection reports done 1 edge after start.
- Pulses: done lasts exactly 1 cycle. err is level-held until a valid start is accepted.
- Back-to-back: start may be high in the same cycle that done is high. It is sampled on that edge only if state is IDLE; in the done cycle state is already IDLE, so it is accepted. Continuous start therefore yields one conversion every BIN_W+1 cycles.
- start while busy (SHIFT/REJECT): ignored, not queued.
- Digit inputs are only sampled on the accepting edge; later changes don't affect the result.
- freq is never partially updated; it changes only at the done edge of a valid conversion.
- After the final step sr_bcd must be 0 for valid input. Implementation asserts this in simulation only (no port).

Optional Feature:
Macro BCD_LEADING_BLANK_EN.
- Defined: digit code 4'hF means "blank" (the display's leading-zero suppression), but only when it is leading, i.e. every more-significant digit is also 4'hF. Leading blanks are converted as 0. A 4'hF after a non-blank digit is invalid and goes to REJECT. All-blank (F,F,F,F) converts to 0.
- Undefined: 4'hF is an invalid digit like 4'hA–4'hE; no blank logic is synthesized.

Test Plan:
1. Reset, then start with digits 0,1,0,5 -> busy for 14 cycles; done pulse in cycle 14 after the start edge; freq=105 (0x069); err=0.
2. Digits 9,9,9,9 -> freq=9999 (0x270F). Then digits 0,0,0,0 -> freq=0; done pulses exactly once per request.
3. After test 2, digits 1,2,A,4 -> done 1 cycle after start; err=1; freq stays 0; busy never asserts. Next valid start 4,3,2,1 -> err clears on the accepting edge; freq=4321.
4. Start held high continuously with 1,2,3,4 -> conversions complete every 15 cycles, each freq=1234. Extra start pulses during SHIFT produce no extra done.
5. Start 8,7,6,5, assert rst_n low at SHIFT step 7 -> all outputs 0 immediately (async), no done. After release, 0,0,4,2 -> freq=42.
6. (BCD_LEADING_BLANK_EN) F,F,0,7 -> freq=7; F,F,F,F -> freq=0; F,3,F,1 -> err=1, freq unchanged. Without the macro, F,F,0,7 -> err=1.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle for the BCD-to-binary entry converter.
// The master drives the request and the digits; the slave returns the result and status.
interface bcd_to_bin_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [3:0]       thous;
  logic [3:0]       hunds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic [BIN_W-1:0] freq;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, thous, hunds, tens, ones,
    input  freq, busy, done, err
  );

  modport slave (
    input  start, thous, hunds, tens, ones,
    output freq, busy, done, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative reverse double-dabble: four packed BCD digits -> BIN_W-bit binary, one step per clock.
// Optional macro BCD_LEADING_BLANK_EN treats leading 4'hF digits as blanks that convert as 0.

module bcd_to_bin_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        last_step,
  input logic [15:0] sr_bcd_next
);
  // For valid digits the BCD register is fully drained when the final step lands.
  a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
    last_step |-> (sr_bcd_next == 16'h0000));
endmodule

module bcd_to_bin #(
  parameter int BIN_W = 14
) (
  input logic         clk,
  input logic         rst_n,
  bcd_to_bin_if.slave bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REJECT = 2'd2
  } state_t;

  function automatic logic digit_ok(input logic [3:0] d);
    logic ok;
    if (d <= 4'd9) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Per-nibble correction after the right shift; no borrow crosses nibble boundaries.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd8) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [15:0]      sr_bcd_r, sr_bcd_s;
  logic [BIN_W-1:0] sr_bin_r, sr_bin_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [BIN_W-1:0] freq_r, freq_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;

  logic [15:0]      dig_s;
  logic [15:0]      load_s;
  logic             digits_ok_s;
  logic [15:0]      bcd_shift_s;
  logic [15:0]      bcd_fix_s;
  logic [BIN_W-1:0] bin_shift_s;
  logic             last_step_s;

  assign dig_s = {bus.thous, bus.hunds, bus.tens, bus.ones};

`ifdef BCD_LEADING_BLANK_EN
  logic [3:0] blank_s;

  // A digit is blank only if it and every more-significant digit are 4'hF.
  assign blank_s[3] = (dig_s[15:12] == 4'hF);
  assign blank_s[2] = blank_s[3] & (dig_s[11:8] == 4'hF);
  assign blank_s[1] = blank_s[2] & (dig_s[7:4]  == 4'hF);
  assign blank_s[0] = blank_s[1] & (dig_s[3:0]  == 4'hF);

  // Validate digits and substitute 0 for leading blanks.
  always_comb begin
    load_s      = 16'h0000;
    digits_ok_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (blank_s[i]) begin
        load_s[4*i +: 4] = 4'h0;
      end else if (digit_ok(dig_s[4*i +: 4])) begin
        load_s[4*i +: 4] = dig_s[4*i +: 4];
      end else begin
        load_s[4*i +: 4] = 4'h0;
        digits_ok_s      = 1'b0;
      end
    end
  end
`else
  // Validate digits; any code above 9 rejects the request.
  always_comb begin
    load_s      = dig_s;
    digits_ok_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (digit_ok(dig_s[4*i +: 4])) begin
        digits_ok_s = digits_ok_s;
      end else begin
        digits_ok_s = 1'b0;
      end
    end
  end
`endif

  // One step of the combined {sr_bcd, sr_bin} right shift with nibble correction.
  always_comb begin
    bcd_shift_s = {1'b0, sr_bcd_r[15:1]};
    bcd_fix_s   = bcd_adjust(bcd_shift_s);
    bin_shift_s = {sr_bcd_r[0], sr_bin_r[BIN_W-1:1]};
    last_step_s = (state_r == ST_SHIFT) && (cnt_r == CNT_W'(BIN_W - 1));
  end

  // Next-state and next-output logic of the conversion FSM.
  always_comb begin
    state_s  = state_r;
    sr_bcd_s = sr_bcd_r;
    sr_bin_s = sr_bin_r;
    cnt_s    = cnt_r;
    freq_s   = freq_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    err_s    = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && digits_ok_s) begin
          sr_bcd_s = load_s;
          sr_bin_s = '0;
          cnt_s    = '0;
          err_s    = 1'b0;
          busy_s   = 1'b1;
          state_s  = ST_SHIFT;
        end else if (bus.start) begin
          done_s  = 1'b1;
          err_s   = 1'b1;
          state_s = ST_REJECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sr_bcd_s = bcd_fix_s;
        sr_bin_s = bin_shift_s;
        cnt_s    = cnt_r + CNT_W'(1);
        if (last_step_s) begin
          freq_s  = bin_shift_s;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          busy_s  = 1'b1;
          state_s = ST_SHIFT;
        end
      end
      ST_REJECT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sr_bcd_r <= 16'h0000;
      sr_bin_r <= '0;
      cnt_r    <= '0;
      freq_r   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      sr_bcd_r <= sr_bcd_s;
      sr_bin_r <= sr_bin_s;
      cnt_r    <= cnt_s;
      freq_r   <= freq_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  assign bus.freq = freq_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;

  bcd_to_bin_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .last_step   (last_step_s),
    .sr_bcd_next (bcd_fix_s)
  );
endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: table of digit vectors with expected result, scored against done pulses.
module tb_bcd_to_bin;
  localparam int BIN_W = 14;

  typedef struct {
    logic [15:0]      dig;
    logic [BIN_W-1:0] freq;
    logic             err;
  } vec_t;

  typedef struct {
    logic [BIN_W-1:0] freq;
    logic             err;
    int               due;
    int               busy;
  } exp_t;

  logic clk;
  logic rst_n;
  int   ncyc;
  int   busy_cnt;
  int   n_chk;
  int   n_bad;
  logic last_err;
  exp_t sb[$];
  vec_t vecs[13];

  bcd_to_bin_if #(.BIN_W(BIN_W)) bif ();

  bcd_to_bin #(.BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, ncyc);
    end
  endfunction

  // Cycle counter and scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bif.busy) busy_cnt = busy_cnt + 1;
      if (bif.done) begin
        check("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_latency", 32'(ncyc), 32'(e.due));
          check("freq", 32'(bif.freq), 32'(e.freq));
          check("err", 32'(bif.err), 32'(e.err));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
          check("busy_at_done", 32'(bif.busy), 32'd0);
        end
        busy_cnt = 0;
      end else if (sb.size() != 0 && ncyc > sb[0].due) begin
        check("done_timeout", 32'd0, 32'd1);
        e = sb.pop_front();
      end
    end
  end

  task automatic drive_digits(input logic [15:0] d);
    {bif.thous, bif.hunds, bif.tens, bif.ones} = d;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
  endtask

  task automatic apply(input logic [15:0] dig, input logic [BIN_W-1:0] ef, input logic ee);
    exp_t e;
    int   n;
    @(negedge clk); #1;
    check("err_held", 32'(bif.err), 32'(last_err));
    bif.start = 1'b1;
    drive_digits(dig);
    n = ncyc;
    e.freq = ef;
    e.err  = ee;
    e.due  = ee ? n + 1 : n + BIN_W + 1;
    e.busy = ee ? 0 : BIN_W;
    sb.push_back(e);
    @(negedge clk); #1;
    bif.start = 1'b0;
    drive_digits(16'($urandom_range(0, 65535)));
    check("busy_after_start", 32'(bif.busy), ee ? 32'd0 : 32'd1);
    if (!ee) check("err_cleared", 32'(bif.err), 32'd0);
    wait_drain();
    last_err = ee;
  endtask

  task automatic check_idle_zero(input string nm);
    check({nm, "_freq"}, 32'(bif.freq), 32'd0);
    check({nm, "_busy"}, 32'(bif.busy), 32'd0);
    check({nm, "_done"}, 32'(bif.done), 32'd0);
    check({nm, "_err"}, 32'(bif.err), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    ncyc     = 0;
    busy_cnt = 0;
    n_chk    = 0;
    n_bad    = 0;
    last_err = 1'b0;

    vecs[0]  = '{16'h0105, 14'd105,  1'b0};
    vecs[1]  = '{16'h9999, 14'd9999, 1'b0};
    vecs[2]  = '{16'h0000, 14'd0,    1'b0};
    vecs[3]  = '{16'h12A4, 14'd0,    1'b1};
    vecs[4]  = '{16'h4321, 14'd4321, 1'b0};
    vecs[5]  = '{16'h0900, 14'd900,  1'b0};
    vecs[6]  = '{16'h1000, 14'd1000, 1'b0};
`ifdef BCD_LEADING_BLANK_EN
    vecs[7]  = '{16'hFF07, 14'd7,    1'b0};
    vecs[8]  = '{16'hB000, 14'd7,    1'b1};
    vecs[9]  = '{16'hFFFF, 14'd0,    1'b0};
    vecs[10] = '{16'hF3F1, 14'd0,    1'b1};
`else
    vecs[7]  = '{16'hFF07, 14'd1000, 1'b1};
    vecs[8]  = '{16'hB000, 14'd1000, 1'b1};
    vecs[9]  = '{16'hFFFF, 14'd1000, 1'b1};
    vecs[10] = '{16'hF3F1, 14'd1000, 1'b1};
`endif
    vecs[11] = '{16'h5060, 14'd5060, 1'b0};
    vecs[12] = '{16'h7777, 14'd7777, 1'b0};

    rst_n     = 1'b0;
    bif.start = 1'b0;
    drive_digits(16'h0000);
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_zero("after_reset");

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].dig, vecs[i].freq, vecs[i].err);
    end

    // Continuous start: three back-to-back conversions, start ignored while shifting.
    @(negedge clk); #1;
    bif.start = 1'b1;
    drive_digits(16'h1234);
    n = ncyc;
    for (int k = 1; k <= 3; k++) begin
      e.freq = 14'd1234;
      e.err  = 1'b0;
      e.due  = n + k * (BIN_W + 1);
      e.busy = BIN_W;
      sb.push_back(e);
    end
    repeat (2 * (BIN_W + 1) + 1) @(negedge clk);
    #1;
    bif.start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    // Reset mid-conversion at SHIFT step 7: no done, outputs cleared at once.
    @(negedge clk); #1;
    bif.start = 1'b1;
    drive_digits(16'h8765);
    @(negedge clk); #1;
    bif.start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    check("pre_reset_busy", 32'(bif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_reset");
    repeat (2) @(negedge clk);
    #1;
    rst_n    = 1'b1;
    last_err = 1'b0;
    repeat (20) @(negedge clk);
    apply(16'h0042, 14'd42, 1'b0);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
